mux9_scan_ctrl: RTL
===================

# mux9_scan_ctrl

Sequencer that sits directly upstream of the 9:1 mux built from 2:1 stages. It drives the mux select lines through channels 0..8, waits a programmable settle time on each, and samples the mux output. It assembles the nine samples into a 9-bit frame and presents it with a one-cycle valid pulse. It supports single-shot and continuous scanning.

## Interface
- SETTLE, default 2: dwell cycles per channel; legal range 1..15; the mux output is sampled on the last edge of each dwell.
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start_i  input  1  scan request; sampled only while idle.
- cont_i  input  1  continuous mode; sampled on the final sample edge of each frame.
- mux_out_i  input  1  output of the 9:1 mux.
- ch_mask_i  input  9  per-channel skip mask, bit k = 1 skips channel k. Present only when MUX9_SCAN_MASK_EN is defined.
- sel_o  output  4  {s3,s2,s1,s0} to the mux. Channel k<8 drives {1'b0,k[2:0]}; channel 8 drives 4'b1000.
- busy_o  output  1  high while a frame is in progress.
- valid_o  output  1  one-cycle pulse when data_o updates.
- data_o  output  9  last completed frame; bit k = sample of channel k.

## Operation
- FSM has two states, IDLE and SCAN. It uses a 4-bit channel index ch (0..8), a 4-bit dwell counter, and a 9-bit shadow register.
- IDLE: sel_o = 4'b0000, busy_o = 0. When start_i = 1, the FSM enters SCAN on that edge with ch = 0 and the dwell counter = SETTLE-1. sel_o shows channel 0 from the next cycle.
- SCAN: each edge with dwell ≠ 0 decrements dwell. On the edge where dwell = 0:
  - mux_out_i is written to shadow[ch];
  - if ch < 8, ch increments and dwell reloads to SETTLE-1;
  - if ch = 8, this is the frame end.
- Frame end, all on the same edge:
  - data_o ← shadow with bit 8 replaced by the current mux_out_i;
  - valid_o is set for exactly one cycle.
  - If cont_i = 1: stay in SCAN, ch = 0, dwell reloads. No idle gap, and busy_o stays high.
  - Otherwise: go to IDLE.
- data_o changes only at frame end, so it is updated atomically and never shows a partial frame.
- start_i is ignored while busy_o = 1. Frames do not queue.
- sel_o is registered and is a pure function of state and ch, so there are no glitches within a dwell.

## Timing
- Reset (rst_n = 0 at an edge): state IDLE, sel_o = 0, busy_o = 0, valid_o = 0, data_o = 0, shadow = 0, ch = 0, dwell = 0.
- Reset asserted mid-frame aborts the frame. data_o is cleared and valid_o is not pulsed.
- Let E0 be the edge that accepts start.
  - sel_o = channel k during cycles after edges E0+k·SETTLE through E0+(k+1)·SETTLE−1.
  - Channel k is sampled at edge E0+(k+1)·SETTLE.
  - valid_o is high in the cycle after edge E0+9·SETTLE.
  - Start-to-valid latency is 9·SETTLE edges.
- busy_o goes high the cycle after E0. In single-shot mode it goes low in the same cycle valid_o is high.
- Continuous mode delivers one frame every 9·SETTLE cycles. Channel 0 of the next frame is selected in the same cycle as the valid_o pulse.
- A new start_i can be accepted in the cycle where valid_o is high, since the FSM is already in IDLE. The next frame then begins back-to-back with a one-cycle idle gap.

## Configuration
- MUX9_SCAN_MASK_EN defined:
  - The ch_mask_i port exists and is latched at frame start (E0, or the continuous restart edge).
  - Masked channels are skipped with zero dwell and read as 0 in data_o.
  - Latency is N·SETTLE, where N is the number of unmasked channels.
  - All nine channels masked: sel_o stays 0, data_o = 0, and valid_o pulses the cycle after E0.
- MUX9_SCAN_MASK_EN undefined: the port is absent and all nine channels are always scanned.

## Test plan
- SETTLE=2; drive mux_out_i from a model of the 9:1 mux with inputs i[8:0]=9'h155; pulse start. Required: sel_o steps 0,1,…,7,8(4'b1000), two cycles each. valid_o pulses 18 cycles after start. data_o=9'h155. busy_o then drops.
- Hold cont_i=1 and change inputs to 9'h0AA mid-frame 1 (just after channel 4 is sampled). Required: frame 2 data_o = 9'h0AA. Frame 1 shows the pre-change values for ch0–4 and the new values for ch5–8. valid_o pulses every 18 cycles.
- Pulse start_i repeatedly while busy. Required: no restart, timing unchanged, only one valid_o pulse.
- Assert rst_n=0 during channel 5. Required: all outputs go to 0 on the next edge, no valid_o pulse, and a fresh start afterwards gives a full 18-cycle frame.
- With MUX9_SCAN_MASK_EN, mask=9'h0F0 and inputs=9'h1FF. Required: sel_o visits 0,1,2,3,8 only. valid_o arrives after 10 cycles. data_o=9'h10F.
- With MUX9_SCAN_MASK_EN, mask=9'h1FF. Required: valid_o the cycle after start, data_o=0, sel_o stays 0.

Source files
------------

// File: rtl/mux9_scan_ctrl.sv
// mux9_scan_ctrl
// ---------------------------------------------------------------------------
// Purpose:
//   Scan sequencer for a 9:1 mux that is built from 2:1 stages. For each
//   channel 0..8 it drives the mux select lines and waits SETTLE cycles. It
//   samples the mux output on the last edge of that dwell. The nine samples
//   are collected in a shadow register. At frame end they are published
//   together on data_o, with a one-cycle valid_o pulse. Scanning can be
//   single-shot (start_i) or continuous (cont_i).
//
// Parameters:
//   SETTLE     dwell cycles per channel, legal range 1..15
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   start_i    scan request, only looked at while idle
//   cont_i     continuous mode, looked at on the final sample edge of a frame
//   mux_out_i  output of the 9:1 mux
//   ch_mask_i  per-channel skip mask (bit k = 1 skips channel k); this port
//              exists only when MUX9_SCAN_MASK_EN is defined
//   sel_o      registered mux select {s3,s2,s1,s0}
//   busy_o     high while a frame is in progress
//   valid_o    one-cycle pulse when data_o updates
//   data_o     last completed frame, bit k = sample of channel k
//
// Build option:
//   MUX9_SCAN_MASK_EN  enables the channel skip mask. When it is undefined,
//                      all nine channels are always scanned.
// ---------------------------------------------------------------------------
module mux9_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       cont_i,
  input  logic       mux_out_i,
  output logic [3:0] sel_o,
  output logic       busy_o,
  output logic       valid_o,
  output logic [8:0] data_o
`ifdef MUX9_SCAN_MASK_EN
  ,
  input  logic [8:0] ch_mask_i
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] DWELL_LOAD = 4'(SETTLE - 1);
  localparam logic [3:0] NO_CH      = 4'd9;

  state_t     state_q, state_d;
  logic [3:0] ch_q, ch_d;
  logic [3:0] dwell_q, dwell_d;
  logic [8:0] shadow_q, shadow_d;
  logic [8:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [3:0] sel_q, sel_d;

  logic [8:0] shadow_w;
  logic [3:0] first_ch;
  logic [3:0] next_ch;
  logic       frame_start;

  // skip_mask applies to the frame in flight. start_mask is the value that
  // gets captured when a frame starts.
  logic [8:0] skip_mask;
  logic [8:0] start_mask;

`ifdef MUX9_SCAN_MASK_EN
  logic [8:0] mask_q, mask_d;

  assign skip_mask  = mask_q;
  assign start_mask = ch_mask_i;

  always_comb begin
    mask_d = mask_q;
    if (frame_start) begin
      mask_d = ch_mask_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= 9'd0;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  assign skip_mask  = 9'd0;
  assign start_mask = 9'd0;
`endif

  // Returns the lowest unskipped channel at or above 'from'.
  // Returns NO_CH when there is none left.
  function automatic logic [3:0] find_ch(input logic [8:0] skip,
                                         input logic [3:0] from);
    logic [3:0] res;
    res = NO_CH;
    for (int i = 8; i >= 0; i--) begin
      if (i >= int'(from) && !skip[i]) begin
        res = 4'(i);
      end
    end
    return res;
  endfunction

  assign first_ch = find_ch(start_mask, 4'd0);
  assign next_ch  = find_ch(skip_mask, 4'(ch_q + 4'd1));

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dwell_d     = dwell_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_start = 1'b0;
    shadow_w    = shadow_q;
    shadow_w[ch_q] = mux_out_i;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          frame_start = 1'b1;
          shadow_d    = 9'd0;
          if (first_ch == NO_CH) begin
            // Every channel is masked, so the frame is empty and completes at once.
            data_d  = 9'd0;
            valid_d = 1'b1;
          end else begin
            state_d = SCAN;
            ch_d    = first_ch;
            dwell_d = DWELL_LOAD;
          end
        end
      end

      SCAN: begin
        if (dwell_q != 4'd0) begin
          dwell_d = dwell_q - 4'd1;
        end else begin
          shadow_d = shadow_w;
          if (next_ch != NO_CH) begin
            ch_d    = next_ch;
            dwell_d = DWELL_LOAD;
          end else begin
            // Frame end: the last sample goes straight into data_o, so
            // data_o never shows a half-updated frame.
            data_d  = shadow_w & ~skip_mask;
            valid_d = 1'b1;
            if (cont_i && first_ch != NO_CH) begin
              frame_start = 1'b1;
              shadow_d    = 9'd0;
              ch_d        = first_ch;
              dwell_d     = DWELL_LOAD;
            end else begin
              state_d = IDLE;
              ch_d    = 4'd0;
              dwell_d = 4'd0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The select value is computed from the next state, so sel_o is a clean
    // register output that is already valid in the first cycle of each dwell.
    // Channel 8 encodes as 4'b1000, which equals the index itself.
    sel_d = (state_d == SCAN) ? ch_d : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= 4'd0;
      dwell_q  <= 4'd0;
      shadow_q <= 9'd0;
      data_q   <= 9'd0;
      valid_q  <= 1'b0;
      sel_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
    end
  end

  assign sel_o   = sel_q;
  assign busy_o  = (state_q == SCAN);
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
